// File: rtl/alu_controller.sv
// ALU control decoder: ALUOp + funct7/funct3 -> registered 4-bit ALU operation and illegal flag.
// Latency: 1 cycle from input presentation to registered output on an enabled clk edge.
// Backpressure: en=0 (pipeline stall) holds both outputs; there is no other handshake.
module alu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] ALUOp,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] operation,
    output logic       illegal
);

    // ALU operation encoding understood by the EX-stage ALU
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001
    } alu_op_e;

    // ALUOp classes from the main control unit
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;

    // The only funct7 encodings RV32I uses for R-type ALU instructions
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    alu_op_e op_d;
    alu_op_e op_q;
    logic    illegal_d;
    logic    illegal_q;
    logic    alt_bit;

    // funct7[5] selects SUB over ADD and SRA over SRL; other funct7 bits only feed the illegal flag
    assign alt_bit = funct7[5];

    // Combinational decode of the operation and the unsupported-encoding flag
    always_comb begin
        op_d      = OP_ADD;
        illegal_d = 1'b0;
        case (ALUOp)
            ALUOP_MEM: begin
                op_d = OP_ADD;
            end
            ALUOP_BR: begin
                op_d = OP_SUB;
            end
            default: begin
                // ALUOp = 10 and 11 are both funct-driven
                case (funct3)
                    3'b000:  op_d = alt_bit ? OP_SUB : OP_ADD;
                    3'b001:  op_d = OP_SLL;
                    3'b010:  op_d = OP_SLT;
                    3'b011:  op_d = OP_SLTU;
                    3'b100:  op_d = OP_XOR;
                    3'b101:  op_d = alt_bit ? OP_SRA : OP_SRL;
                    3'b110:  op_d = OP_OR;
                    default: op_d = OP_AND;
                endcase
                // Flag only: the operation above is still issued so the pipeline never traps here
                if (funct7 == F7_BASE) begin
                    illegal_d = 1'b0;
                end else if (funct7 == F7_ALT) begin
                    illegal_d = !((funct3 == 3'b000) || (funct3 == 3'b101));
                end else begin
                    illegal_d = 1'b1;
                end
            end
        endcase
    end

    // Output register aligned with ID/EX; reset forces ADD immediately, en=0 stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_ADD;
            illegal_q <= 1'b0;
        end else if (en) begin
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign operation = op_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed-vector bench for alu_controller with an exhaustive funct-class sweep.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Stall behaviour is exercised by holding en low across changing inputs.
module tb_alu_controller;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] ALUOp;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [3:0] operation;
    logic       illegal;

    int n_tests;
    int n_fail;

    alu_controller dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ALUOp     (ALUOp),
        .funct7    (funct7),
        .funct3    (funct3),
        .operation (operation),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch
    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one input vector at the falling edge, let one rising edge capture it, sample just after
    task automatic apply(input logic e, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        @(negedge clk);
        en     = e;
        ALUOp  = op;
        funct7 = f7;
        funct3 = f3;
        @(posedge clk);
        #1;
    endtask

    // Reference: ALU code table indexed by {funct3, funct7[5]}
    function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] tbl [16];
        tbl = '{4'b0010, 4'b0110,   // 000 ADD / SUB
                4'b0100, 4'b0100,   // 001 SLL
                4'b1000, 4'b1000,   // 010 SLT
                4'b1001, 4'b1001,   // 011 SLTU
                4'b0011, 4'b0011,   // 100 XOR
                4'b0101, 4'b0111,   // 101 SRL / SRA
                4'b0001, 4'b0001,   // 110 OR
                4'b0000, 4'b0000};  // 111 AND
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        return tbl[{f3, f7[5]}];
    endfunction

    function automatic logic ref_ill(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        if (!op[1]) return 1'b0;
        if (f7 == 7'd0) return 1'b0;
        if (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        en      = 1'b0;
        ALUOp   = 2'b10;
        funct7  = 7'b0100000;
        funct3  = 3'b000;

        // Reset asserted from time zero: outputs must be ADD / not illegal before any clock edge
        reset = 1'b1;
        #2;
        check_eq("reset_op", operation, 4'b0010);
        check_eq("reset_ill", {3'b0, illegal}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // ALUOp=00 and 01 ignore the funct fields
        apply(1'b1, 2'b00, 7'b0101011, 3'b111);
        check_eq("mem_op", operation, 4'b0010);
        check_eq("mem_ill", {3'b0, illegal}, 4'b0000);
        apply(1'b1, 2'b01, 7'b0101011, 3'b111);
        check_eq("br_op", operation, 4'b0110);
        check_eq("br_ill", {3'b0, illegal}, 4'b0000);

        // Hand-computed R-type cases for both ALUOp=10 and 11
        for (int a = 2; a < 4; a++) begin
            apply(1'b1, 2'(a), 7'b0000000, 3'b000);
            check_eq("rt_add", operation, 4'b0010);
            apply(1'b1, 2'(a), 7'b0100000, 3'b000);
            check_eq("rt_sub", operation, 4'b0110);
            apply(1'b1, 2'(a), 7'b0000000, 3'b111);
            check_eq("rt_and", operation, 4'b0000);
            apply(1'b1, 2'(a), 7'b0000000, 3'b110);
            check_eq("rt_or", operation, 4'b0001);
            apply(1'b1, 2'(a), 7'b0100000, 3'b101);
            check_eq("rt_sra", operation, 4'b0111);
            check_eq("rt_sra_ill", {3'b0, illegal}, 4'b0000);
        end

        // Illegal encodings still issue the table operation
        apply(1'b1, 2'b11, 7'b1111111, 3'b111);
        check_eq("ill_f7_op", operation, 4'b0000);
        check_eq("ill_f7_flag", {3'b0, illegal}, 4'b0001);
        apply(1'b1, 2'b10, 7'b0100000, 3'b110);
        check_eq("ill_f3_op", operation, 4'b0001);
        check_eq("ill_f3_flag", {3'b0, illegal}, 4'b0001);

        // Asynchronous reset mid-cycle, away from any clock edge
        apply(1'b1, 2'b01, 7'b1111111, 3'b010);
        check_eq("pre_areset_op", operation, 4'b0110);
        apply(1'b1, 2'b11, 7'b1111111, 3'b010);
        check_eq("pre_areset_ill", {3'b0, illegal}, 4'b0001);
        #1;
        reset = 1'b1;
        #1;
        check_eq("areset_op", operation, 4'b0010);
        check_eq("areset_ill", {3'b0, illegal}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Stall: en=0 for three cycles while inputs move from the ADD case to the SUB case
        apply(1'b1, 2'b10, 7'b0000000, 3'b000);
        check_eq("stall_pre", operation, 4'b0010);
        apply(1'b0, 2'b10, 7'b0100000, 3'b000);
        check_eq("stall_1", operation, 4'b0010);
        apply(1'b0, 2'b01, 7'b0100000, 3'b000);
        check_eq("stall_2", operation, 4'b0010);
        apply(1'b0, 2'b10, 7'b0100000, 3'b000);
        check_eq("stall_3", operation, 4'b0010);
        apply(1'b1, 2'b10, 7'b0100000, 3'b000);
        check_eq("stall_release", operation, 4'b0110);

        // Exhaustive sweep of the funct-driven classes against the reference tables
        for (int a = 2; a < 4; a++) begin
            for (int f7 = 0; f7 < 128; f7++) begin
                for (int f3 = 0; f3 < 8; f3++) begin
                    apply(1'b1, 2'(a), 7'(f7), 3'(f3));
                    check_eq($sformatf("sweep_op a%0d f7=%0d f3=%0d", a, f7, f3),
                             operation, ref_op(2'(a), 7'(f7), 3'(f3)));
                    check_eq($sformatf("sweep_ill a%0d f7=%0d f3=%0d", a, f7, f3),
                             {3'b0, illegal}, {3'b0, ref_ill(2'(a), 7'(f7), 3'(f3))});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
